// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel coordinates, display enable, sync pulses
// and a delayed copy of the syncs aligned with a registered colour pipeline.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        h_wrap;
  logic        frame_next;
  logic        first_seen;

  // NOTE: every always_comb output gets a value on every path (here via
  // defaults first), otherwise synthesis infers a latch.
  always_comb begin
    h_wrap     = 1'b0;
    x_next     = DrawX + 10'd1;
    y_next     = DrawY;
    if (DrawX == H_LAST) begin
      h_wrap = 1'b1;
      x_next = '0;
      y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    end
    x_ext      = {1'b0, x_next};
    y_ext      = {1'b0, y_next};
    frame_next = (x_next == '0) && (y_next == '0);
  end

  // Flags are registered from the next counter values so they line up with
  // the DrawX/DrawY they describe, with no combinational path to the ports.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      first_seen  <= 1'b0;
    end else begin
      DrawX       <= x_next;
      DrawY       <= y_next;
      blank       <= (x_ext < H_VIS) && (y_ext < V_VIS);
      hs          <= !((x_ext >= HS_START) && (x_ext < HS_END));
      vs          <= !((y_ext >= VS_START) && (y_ext < VS_END));
      line_start  <= (x_next == '0);
      frame_start <= frame_next;
      // The pulse right after reset starts frame 0 rather than completing one.
      if (frame_next) begin
        if (first_seen)
          frame_count <= frame_count + 8'd1;
        first_seen <= 1'b1;
      end
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign hs_d = hs;
      assign vs_d = vs;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe;
      logic [PIPE_DELAY-1:0] vs_pipe;

      // Stages reset idle-high so no partial sync pulse reaches the connector.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe[0] <= hs;
          vs_pipe[0] <= vs;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign hs_d = hs_pipe[PIPE_DELAY-1];
      assign vs_d = vs_pipe[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instances (delays 1, 3, 0) and a
// shrunken-raster instance, all checked each cycle against an arithmetic model.
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hfp; int hsy; int hbp;
    int vv; int vfp; int vsy; int vbp;
    int d;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       hs_d;
    logic       vs_d;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic       vga_clk;
  logic       reset;
  logic [9:0] dx  [4];
  logic [9:0] dy  [4];
  logic       bl  [4];
  logic       hs  [4];
  logic       vs  [4];
  logic       hsd [4];
  logic       vsd [4];
  logic       ls  [4];
  logic       fs  [4];
  logic [7:0] fc  [4];

  cfg_t cfgs [4];
  int   checks = 0;
  int   errors = 0;
  bit   rst_seen = 1'b0;
  bit   valid = 1'b0;
  int   k = 0;

  vga_timing_gen #(.PIPE_DELAY(1)) dut_a (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]),
    .hs(hs[0]), .vs(vs[0]), .hs_d(hsd[0]), .vs_d(vsd[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .frame_count(fc[0]));

  vga_timing_gen #(.PIPE_DELAY(3)) dut_b (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]),
    .hs(hs[1]), .vs(vs[1]), .hs_d(hsd[1]), .vs_d(vsd[1]), .line_start(ls[1]),
    .frame_start(fs[1]), .frame_count(fc[1]));

  vga_timing_gen #(.PIPE_DELAY(0)) dut_c (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]),
    .hs(hs[2]), .vs(vs[2]), .hs_d(hsd[2]), .vs_d(vsd[2]), .line_start(ls[2]),
    .frame_start(fs[2]), .frame_count(fc[2]));

  // 16 x 10 raster so whole frames and the 8-bit frame counter wrap are cheap.
  vga_timing_gen #(
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(1)
  ) dut_s (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[3]), .DrawY(dy[3]), .blank(bl[3]),
    .hs(hs[3]), .vs(vs[3]), .hs_d(hsd[3]), .vs_d(vsd[3]), .line_start(ls[3]),
    .frame_start(fs[3]), .frame_count(fc[3]));

  initial begin
    vga_clk = 1'b0;
    forever #20 vga_clk = ~vga_clk;
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
    end
  endtask

  function automatic logic in_pulse(input int v, input int start, input int width);
    return (v >= start) && (v < start + width);
  endfunction

  // k = rising edges since the last edge that sampled reset high; the raster
  // position is simply (k - 1) mod frame length, with reset parked on the
  // last position of the frame.
  function automatic exp_t model(input int kk, input cfg_t c);
    exp_t e;
    int ht, vt, tot, p, x, y, pd;
    ht  = c.hv + c.hfp + c.hsy + c.hbp;
    vt  = c.vv + c.vfp + c.vsy + c.vbp;
    tot = ht * vt;
    p   = (tot - 1 + kk) % tot;
    x   = p % ht;
    y   = p / ht;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.blank = (x < c.hv) && (y < c.vv);
    e.hs    = !in_pulse(x, c.hv + c.hfp, c.hsy);
    e.vs    = !in_pulse(y, c.vv + c.vfp, c.vsy);
    e.ls    = (x == 0);
    e.fs    = (p == 0);
    e.fc    = (kk >= 1) ? 8'(((kk - 1) / tot) % 256) : 8'd0;
    if (kk >= c.d) begin
      pd     = (tot - 1 + kk - c.d) % tot;
      e.hs_d = !in_pulse(pd % ht, c.hv + c.hfp, c.hsy);
      e.vs_d = !in_pulse(pd / ht, c.vv + c.vfp, c.vsy);
    end else begin
      e.hs_d = 1'b1;
      e.vs_d = 1'b1;
    end
    return e;
  endfunction

  always @(posedge vga_clk) rst_seen <= reset;

  always @(negedge vga_clk) begin
    exp_t e;
    if (rst_seen) begin
      k     = 0;
      valid = 1'b1;
    end else if (valid) begin
      k++;
    end
    if (valid) begin
      for (int i = 0; i < 4; i++) begin
        e = model(k, cfgs[i]);
        check("x",      i, 32'(dx[i]),  32'(e.x));
        check("y",      i, 32'(dy[i]),  32'(e.y));
        check("blank",  i, 32'(bl[i]),  32'(e.blank));
        check("hs",     i, 32'(hs[i]),  32'(e.hs));
        check("vs",     i, 32'(vs[i]),  32'(e.vs));
        check("hs_d",   i, 32'(hsd[i]), 32'(e.hs_d));
        check("vs_d",   i, 32'(vsd[i]), 32'(e.vs_d));
        check("line_s", i, 32'(ls[i]),  32'(e.ls));
        check("frame_s",i, 32'(fs[i]),  32'(e.fs));
        check("fcount", i, 32'(fc[i]),  32'(e.fc));
      end
    end
  end

  initial begin
    bit found;
    cfgs[0] = '{hv:640, hfp:16, hsy:96, hbp:48, vv:480, vfp:10, vsy:2, vbp:33, d:1};
    cfgs[1] = '{hv:640, hfp:16, hsy:96, hbp:48, vv:480, vfp:10, vsy:2, vbp:33, d:3};
    cfgs[2] = '{hv:640, hfp:16, hsy:96, hbp:48, vv:480, vfp:10, vsy:2, vbp:33, d:0};
    cfgs[3] = '{hv:10,  hfp:2,  hsy:2,  hbp:2,  vv:6,   vfp:1,  vsy:2, vbp:1,  d:1};

    reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check("lit_rst_x",     0, 32'(dx[0]), 799);
    check("lit_rst_y",     0, 32'(dy[0]), 524);
    check("lit_rst_hs",    0, 32'(hs[0]), 1);
    check("lit_rst_vs",    0, 32'(vs[0]), 1);
    check("lit_rst_blank", 0, 32'(bl[0]), 0);
    reset = 1'b0;

    @(negedge vga_clk);
    check("lit_first_x",  0, 32'(dx[0]), 0);
    check("lit_first_y",  0, 32'(dy[0]), 0);
    check("lit_first_bl", 0, 32'(bl[0]), 1);
    check("lit_first_fs", 0, 32'(fs[0]), 1);
    check("lit_first_ls", 0, 32'(ls[0]), 1);
    check("lit_first_fc", 0, 32'(fc[0]), 0);

    repeat (639) @(negedge vga_clk);
    check("lit_bl_639", 0, 32'(bl[0]), 1);
    @(negedge vga_clk);
    check("lit_bl_640", 0, 32'(bl[0]), 0);
    repeat (15) @(negedge vga_clk);
    check("lit_hs_655", 0, 32'(hs[0]), 1);
    @(negedge vga_clk);
    check("lit_hs_656",    0, 32'(hs[0]),  0);
    check("lit_hsd1_656",  0, 32'(hsd[0]), 1);
    check("lit_hsd3_656",  1, 32'(hsd[1]), 1);
    check("lit_hsd0_656",  2, 32'(hsd[2]), 0);
    @(negedge vga_clk);
    check("lit_hsd1_657",  0, 32'(hsd[0]), 0);
    @(negedge vga_clk);
    check("lit_hsd3_658",  1, 32'(hsd[1]), 1);
    @(negedge vga_clk);
    check("lit_hsd3_659",  1, 32'(hsd[1]), 0);
    repeat (92) @(negedge vga_clk);
    check("lit_hs_751", 0, 32'(hs[0]), 0);
    @(negedge vga_clk);
    check("lit_hs_752", 0, 32'(hs[0]), 1);
    repeat (47) @(negedge vga_clk);
    check("lit_bl_799", 0, 32'(bl[0]), 0);
    check("lit_ls_799", 0, 32'(ls[0]), 0);
    @(negedge vga_clk);
    check("lit_line1_x",  0, 32'(dx[0]), 0);
    check("lit_line1_y",  0, 32'(dy[0]), 1);
    check("lit_line1_ls", 0, 32'(ls[0]), 1);
    check("lit_line1_fs", 0, 32'(fs[0]), 0);

    // Reset mid-frame on the small raster while hs, vs and both delayed syncs are low.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge vga_clk);
      if (dx[3] == 10'd13 && dy[3] == 10'd7) found = 1'b1;
    end
    check("mid_pos_found", 3, 32'(found),  1);
    check("mid_hs_low",    3, 32'(hs[3]),  0);
    check("mid_vs_low",    3, 32'(vs[3]),  0);
    check("mid_hsd_low",   3, 32'(hsd[3]), 0);
    check("mid_vsd_low",   3, 32'(vsd[3]), 0);
    reset = 1'b1;
    @(negedge vga_clk);
    check("mid_rst_x",   3, 32'(dx[3]),  15);
    check("mid_rst_y",   3, 32'(dy[3]),  9);
    check("mid_rst_hs",  3, 32'(hs[3]),  1);
    check("mid_rst_vs",  3, 32'(vs[3]),  1);
    check("mid_rst_hsd", 3, 32'(hsd[3]), 1);
    check("mid_rst_vsd", 3, 32'(vsd[3]), 1);
    check("mid_rst_fc",  3, 32'(fc[3]),  0);
    check("mid_rst_ax",  0, 32'(dx[0]),  799);
    reset = 1'b0;
    @(negedge vga_clk);
    check("resume_x",  3, 32'(dx[3]), 0);
    check("resume_y",  3, 32'(dy[3]), 0);
    check("resume_fs", 3, 32'(fs[3]), 1);
    check("resume_fc", 3, 32'(fc[3]), 0);

    repeat (160) @(negedge vga_clk);
    check("frame2_fs", 3, 32'(fs[3]), 1);
    check("frame2_fc", 3, 32'(fc[3]), 1);
    repeat (40640) @(negedge vga_clk);
    check("frame256_fs", 3, 32'(fs[3]), 1);
    check("frame256_fc", 3, 32'(fc[3]), 255);
    repeat (159) @(negedge vga_clk);
    check("pre257_fs", 3, 32'(fs[3]), 0);
    check("pre257_fc", 3, 32'(fc[3]), 255);
    @(negedge vga_clk);
    check("frame257_fs", 3, 32'(fs[3]), 1);
    check("frame257_fc", 3, 32'(fc[3]), 0);
    check("frame257_x",  3, 32'(dx[3]), 0);
    check("frame257_y",  3, 32'(dy[3]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock. Provides the pixel coordinates (DrawX, DrawY) and the active-video enable (`blank`, high = visible) consumed by the sprite/palette rendering stages. Also provides the hs/vs sync pulses, plus copies of them delayed to line up with the one-cycle registered colour output of those stages. Sits directly upstream of every pixel renderer and directly drives the VGA connector sync pins.

## Interface

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 1, cycles of delay on hs_d/vs_d; legal range 0..7

Derived constants: H_TOTAL = 800 and V_TOTAL = 525 with the default parameters.

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- blank  out  1  1 when DrawX < H_VISIBLE and DrawY < V_VISIBLE (display enable)
- hs  out  1  horizontal sync, active low, aligned with DrawX/DrawY
- vs  out  1  vertical sync, active low, aligned with DrawX/DrawY
- hs_d  out  1  hs delayed PIPE_DELAY cycles; drives the connector
- vs_d  out  1  vs delayed PIPE_DELAY cycles; drives the connector
- line_start  out  1  one-cycle pulse when DrawX == 0
- frame_start  out  1  one-cycle pulse when DrawX == 0 and DrawY == 0
- frame_count  out  8  completed-frame counter, wraps 255 -> 0

## Operation

- **Horizontal counter (DrawX):** counts 0..H_TOTAL-1, then wraps to 0.
- **Vertical counter (DrawY):** increments only on the cycle where DrawX wraps. It wraps V_TOTAL-1 -> 0 when both counters wrap together.
- **Registered outputs:** hs, vs, blank, line_start and frame_start are registers computed from the *next* counter values. They are therefore valid in the same cycle as the DrawX/DrawY they describe. No combinational path from counters to ports.
- **hs:** low iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
- **vs:** low iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC, i.e. lines 490..491, for the full 800 clocks of each of those lines.
- **frame_count:** increments by 1 mod 256 on every frame_start, except the first frame_start after reset.
- **Delay line:** hs_d/vs_d come from a PIPE_DELAY-deep shift register. With PIPE_DELAY = 0 they equal hs/vs.
- **Counter widths:** 10 bits unsigned. No comparisons may overflow: compare in 11 bits where sums are formed.

## Timing

- **Reset values** (reset high at a rising edge): DrawX = H_TOTAL-1, DrawY = V_TOTAL-1, blank = 0, hs = 1, vs = 1, line_start = 0, frame_start = 0, frame_count = 0, every delay-line stage = 1.
  - These values are self-consistent for position (799, 524).
- **First edge after reset release:** DrawX = 0, DrawY = 0, blank = 1, line_start = 1, frame_start = 1. frame_count stays 0 on this first pulse.
- **Reset mid-frame:** takes effect at the next edge regardless of position. No partial sync pulse survives: hs_d/vs_d also force to 1.
- **Sync latency:** hs_d/vs_d transitions lag hs/vs by exactly PIPE_DELAY cycles.
- **Line timing:** blank falls at the edge where DrawX goes 639 -> 640 and rises at 799 -> 0, on lines 0..479 only.
- **Vertical blanking:** during lines 480..524, blank stays 0 for the entire line.
- **Frame period:** exactly 420000 clocks between frame_start pulses.
- **Line period:** exactly 800 clocks between line_start pulses.
- **Simultaneous wrap** (DrawX = 799, DrawY = 524): both counters go to 0 in one edge, and line_start and frame_start assert together.

## Test plan

- Reset 3 cycles, release -> next cycle DrawX = 0, DrawY = 0, blank = 1, frame_start = 1, frame_count = 0; the preceding cycle shows DrawX = 799, DrawY = 524, hs = vs = 1.
- Run one line on DrawY = 0 -> hs falls when DrawX = 656 and rises when DrawX = 752 (96 clocks low); blank = 0 from DrawX = 640 through 799; line_start exactly once per 800 clocks.
- Run a full frame -> vs low only while DrawY is 490 or 491 (1600 clocks); blank never 1 for DrawY >= 480; next frame_start 420000 clocks after the first; frame_count = 1.
- PIPE_DELAY = 1 and PIPE_DELAY = 3 builds -> hs_d falling edge at DrawX = 657 and DrawX = 659 respectively; PIPE_DELAY = 0 -> hs_d == hs every cycle.
- Assert reset for one cycle at DrawX = 700, DrawY = 490 (hs and vs both low) -> next cycle hs = vs = hs_d = vs_d = 1, DrawX = 799, DrawY = 524, frame_count = 0; normal sequencing resumes from (0, 0).
- Free-run 257 frames after reset -> frame_count reads 255 after the 256th frame_start and wraps to 0 on the 257th.
